buyruk_kuyrugu: RTL and testbench
=================================

# buyruk_kuyrugu

Instruction issue queue placed directly upstream of the `yurutucu` executor. It buffers a program of ADD/MUL register instructions written by the loader and presents them in order, one per accepted cycle, on the executor's `ky1`/`ky2`/`hy`/`islem` fields. When the program is marked complete and fully drained, it raises `bitir` to the executor. It also absorbs executor back-pressure through `durdur`.

## Interface

Parameters:
- DERINLIK, default 8: number of entries; must be a power of 2, at least 2.

Ports:
- saat  in  1  clock; all state changes on the rising edge
- sifirla  in  1  asynchronous, active-high reset
- yaz_gecerli  in  1  loader offers one instruction this cycle
- yaz_hazir  out  1  queue accepts the offered instruction at this edge
- yaz_islem  in  1  offered operation: 1 = ADD, 0 = MUL
- yaz_hy  in  2  offered destination register
- yaz_ky1  in  2  offered source register 1
- yaz_ky2  in  2  offered source register 2
- yaz_son  in  1  offered instruction is the last one of the program; sampled only with yaz_gecerli
- durdur  in  1  executor stall; the head entry is not consumed
- gecerli  out  1  head instruction is presented this cycle
- islem, hy, ky1, ky2  out  1/2/2/2  head instruction fields; all 0 when gecerli=0
- bitir  out  1  program sealed and fully issued; sticky until reset
- doluluk  out  $clog2(DERINLIK)+1  current occupancy, 0..DERINLIK

## Operation

- Storage: DERINLIK × 7-bit entries {islem, hy, ky1, ky2}, held in registers.
- Write and read pointers are $clog2(DERINLIK) bits wide and wrap modulo DERINLIK. Occupancy is a separate counter.
- Push occurs when `yaz_gecerli && yaz_hazir`.
- Pop occurs when `gecerli && !durdur`.
- Head outputs are read combinationally from mem[rd_ptr], gated by gecerli. `gecerli = (doluluk != 0)`.
- Push and pop in the same cycle: both pointers advance and doluluk is unchanged.
- Full: `yaz_hazir = 0`, even if a pop occurs in the same cycle. The offered entry is not written.
- Empty: gecerli=0 and the fields read 0. A same-cycle push is accepted and appears after the edge.

State machine (2-bit, registered):
- DOLDUR: accepting entries; `yaz_hazir = (doluluk != DERINLIK)`. A push with yaz_son=1 moves to MUHURLU.
- MUHURLU: `yaz_hazir = 0`; further yaz_gecerli is ignored. A pop that leaves doluluk at 0 moves to BITTI.
- BITTI: `yaz_hazir = 0`, `bitir = 1`. The block stays in BITTI until sifirla.
- Unused state encoding: returns to DOLDUR.

Reset:
- sifirla asserted at any time, including mid-drain or in BITTI, immediately clears the pointers, doluluk, and state (to DOLDUR). Stored data need not be cleared.
- Outputs during and after reset: gecerli=0, fields=0, bitir=0, doluluk=0, yaz_hazir=1.

## Timing

- Push at edge N: the entry is visible on the outputs after edge N if the queue was empty. Otherwise it appears after all older entries have popped.
- Throughput: one push and one pop per cycle sustained. Latency through an empty queue is 1 cycle.
- durdur=1 with gecerli=1: islem/hy/ky1/ky2 hold stable across every stalled cycle.
- bitir rises after the edge at which the final (yaz_son) entry pops. At that same edge, gecerli falls to 0.
- yaz_hazir depends only on the state and doluluk registers, with no combinational path from yaz_gecerli or durdur.

## Test plan

1. **Reset mid-drain.** Push 3 entries, pop 1, then pulse sifirla between edges. Required: doluluk=0, gecerli=0, bitir=0, and yaz_hazir=1 immediately, without waiting for an edge.
2. **Two-instruction program, durdur=0.**
   - Stimulus: push ADD R2←R0,R1 (islem=1, hy=2, ky1=0, ky2=1). Next cycle, push MUL R0←R2,R3 with yaz_son=1.
   - Required: the outputs show {1,2,0,1} and then {0,0,2,3} on consecutive cycles. After the MUL pop edge, gecerli=0 and bitir=1, and both stay that way for 10 cycles.
3. **Full boundary, DERINLIK=8, durdur=1.**
   - Stimulus: offer 9 entries.
   - Required: 8 are accepted, doluluk=8, and yaz_hazir=0 while the 9th is held. Then drop durdur for one cycle.
   - Required after the pop: doluluk=7 and yaz_hazir=1. The 9th entry is accepted next and lands behind entry 8.
4. **Wrap-around streaming.** Push 20 distinct entries back-to-back with durdur=0. Required: doluluk holds 1 after the first push, and the pop order matches the push order exactly across pointer wrap.
5. **Stall hold.** With head MUL R1←R3,R2, hold durdur=1 for 5 cycles. Required: gecerli=1 and fields {0,1,3,2} remain unchanged throughout, with no pop.
6. **Seal.** After an entry with yaz_son is accepted, hold yaz_gecerli=1 for 4 cycles. Required: yaz_hazir=0, doluluk does not increase, and those pushes are never issued.

Source files
------------

// File: rtl/buyruk_kuyrugu.sv
// buyruk_kuyrugu
// In-order issue queue for ADD/MUL register instructions feeding the
// yurutucu executor. The loader writes a program, the last instruction
// marked with yaz_son; the queue then refuses further writes, drains,
// and raises bitir once the final instruction has been issued.
//
// Ports
//   saat         clock, rising edge
//   sifirla      asynchronous active-high reset
//   yaz_gecerli  loader offers an instruction
//   yaz_hazir    queue accepts the offered instruction at this edge
//   yaz_islem    offered op (1 = ADD, 0 = MUL)
//   yaz_hy       offered destination register
//   yaz_ky1      offered source register 1
//   yaz_ky2      offered source register 2
//   yaz_son      offered instruction ends the program
//   durdur       executor stall, head is not consumed
//   gecerli      head instruction is presented
//   islem/hy/ky1/ky2  head fields, forced to 0 when gecerli=0
//   bitir        program sealed and fully issued (sticky)
//   doluluk      occupancy, 0..DERINLIK
//
// state   | meaning
// --------+---------------------------------------------------
// DOLDUR  | accepting instructions while not full
// MUHURLU | last instruction received, draining, writes refused
// BITTI   | everything issued, bitir held until reset

module buyruk_kuyrugu #(
    parameter int DERINLIK = 8
) (
    input  logic                      saat,
    input  logic                      sifirla,
    input  logic                      yaz_gecerli,
    output logic                      yaz_hazir,
    input  logic                      yaz_islem,
    input  logic [1:0]                yaz_hy,
    input  logic [1:0]                yaz_ky1,
    input  logic [1:0]                yaz_ky2,
    input  logic                      yaz_son,
    input  logic                      durdur,
    output logic                      gecerli,
    output logic                      islem,
    output logic [1:0]                hy,
    output logic [1:0]                ky1,
    output logic [1:0]                ky2,
    output logic                      bitir,
    output logic [$clog2(DERINLIK):0] doluluk
);

    localparam int PW = $clog2(DERINLIK);
    localparam logic [PW:0] DOLU = (PW+1)'(DERINLIK);
    localparam logic [PW:0] BIR  = (PW+1)'(1);

    typedef enum logic [1:0] {
        DOLDUR  = 2'd0,
        MUHURLU = 2'd1,
        BITTI   = 2'd2
    } durum_t;

    durum_t durum, durum_sonraki;

    logic [6:0]    mem [DERINLIK];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [6:0]    bas;

    assign gecerli = (doluluk != '0);
    assign push    = yaz_gecerli && yaz_hazir;
    assign pop     = gecerli && !durdur;

    // Head fields come straight from storage; gating keeps them at zero
    // whenever the queue is empty, including the stale data after reset.
    assign bas                  = gecerli ? mem[rd_ptr] : 7'd0;
    assign {islem, hy, ky1, ky2} = bas;

    always_ff @(posedge saat or posedge sifirla) begin
        if (sifirla) begin
            durum <= DOLDUR;
        end else begin
            durum <= durum_sonraki;
        end
    end

    // yaz_hazir is a function of registered state only; the next-state
    // logic repeats the full test rather than reading push so no path
    // runs from yaz_gecerli back into yaz_hazir.
    always_comb begin
        durum_sonraki = durum;
        yaz_hazir     = 1'b0;
        bitir         = 1'b0;
        case (durum)
            DOLDUR: begin
                yaz_hazir = (doluluk != DOLU);
                if (yaz_gecerli && (doluluk != DOLU) && yaz_son) begin
                    durum_sonraki = MUHURLU;
                end
            end
            MUHURLU: begin
                if (pop && (doluluk == BIR)) begin
                    durum_sonraki = BITTI;
                end
            end
            BITTI: begin
                bitir = 1'b1;
            end
            default: begin
                durum_sonraki = DOLDUR;
            end
        endcase
    end

    always_ff @(posedge saat or posedge sifirla) begin
        if (sifirla) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            doluluk <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   doluluk <= doluluk + 1'b1;
                2'b01:   doluluk <= doluluk - 1'b1;
                default: doluluk <= doluluk;
            endcase
        end
    end

    // Storage needs no reset: gecerli masks anything not written since.
    always_ff @(posedge saat) begin
        if (push) begin
            mem[wr_ptr] <= {yaz_islem, yaz_hy, yaz_ky1, yaz_ky2};
        end
    end

endmodule

// File: tb/tb_buyruk_kuyrugu.sv
module tb_buyruk_kuyrugu;

    logic       saat = 1'b0;
    logic       sifirla;
    logic       yaz_gecerli;
    logic       yaz_hazir;
    logic       yaz_islem;
    logic [1:0] yaz_hy;
    logic [1:0] yaz_ky1;
    logic [1:0] yaz_ky2;
    logic       yaz_son;
    logic       durdur;
    logic       gecerli;
    logic       islem;
    logic [1:0] hy;
    logic [1:0] ky1;
    logic [1:0] ky2;
    logic       bitir;
    logic [3:0] doluluk;

    int total = 0;
    int bad   = 0;
    logic [6:0] sb [$];

    always #5 saat = ~saat;

    buyruk_kuyrugu #(.DERINLIK(8)) dut (
        .saat(saat), .sifirla(sifirla),
        .yaz_gecerli(yaz_gecerli), .yaz_hazir(yaz_hazir),
        .yaz_islem(yaz_islem), .yaz_hy(yaz_hy), .yaz_ky1(yaz_ky1), .yaz_ky2(yaz_ky2),
        .yaz_son(yaz_son), .durdur(durdur),
        .gecerli(gecerli), .islem(islem), .hy(hy), .ky1(ky1), .ky2(ky2),
        .bitir(bitir), .doluluk(doluluk)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every negedge where the head will be consumed, compare it
    // against the oldest expected entry.
    initial begin
        forever begin
            @(negedge saat);
            if (!sifirla) begin
                if (!gecerli) begin
                    chk("idle_fields", {islem, hy, ky1, ky2}, 0);
                end else if (!durdur) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_issue", {islem, hy, ky1, ky2}, -1);
                    end else begin
                        chk("issue_order", {islem, hy, ky1, ky2}, sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge saat);
        #1;
    endtask

    // Called at posedge+1; reset is pulsed between edges and the outputs
    // are checked while it is still asserted.
    task automatic do_reset();
        sifirla = 1'b1;
        #1;
        chk("rst_doluluk", doluluk, 0);
        chk("rst_gecerli", gecerli, 0);
        chk("rst_bitir", bitir, 0);
        chk("rst_yaz_hazir", yaz_hazir, 1);
        chk("rst_fields", {islem, hy, ky1, ky2}, 0);
        sb.delete();
        #1;
        sifirla = 1'b0;
        step();
    endtask

    task automatic offer(input logic [6:0] e, input logic son, input logic exp_acc);
        yaz_gecerli = 1'b1;
        {yaz_islem, yaz_hy, yaz_ky1, yaz_ky2} = e;
        yaz_son = son;
        @(negedge saat);
        chk("yaz_hazir", yaz_hazir, exp_acc);
        if (exp_acc) sb.push_back(e);
        step();
        yaz_gecerli = 1'b0;
        yaz_son     = 1'b0;
    endtask

    task automatic drain();
        int n;
        durdur = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 100, 1);
        chk("drain_doluluk", doluluk, 0);
    endtask

    initial begin
        sifirla     = 1'b1;
        yaz_gecerli = 1'b0;
        yaz_islem   = 1'b0;
        yaz_hy      = 2'd0;
        yaz_ky1     = 2'd0;
        yaz_ky2     = 2'd0;
        yaz_son     = 1'b0;
        durdur      = 1'b1;
        step();
        sifirla = 1'b0;
        step();

        // 1: reset while draining
        offer(7'h11, 1'b0, 1'b1);
        offer(7'h22, 1'b0, 1'b1);
        offer(7'h33, 1'b0, 1'b1);
        chk("t1_doluluk3", doluluk, 3);
        durdur = 1'b0;
        step();
        durdur = 1'b1;
        chk("t1_doluluk2", doluluk, 2);
        do_reset();

        // 2: ADD R2<-R0,R1 then MUL R0<-R2,R3 as last
        durdur = 1'b0;
        offer(7'b1_10_00_01, 1'b0, 1'b1);
        chk("t2_add_head", {gecerli, islem, hy, ky1, ky2}, {1'b1, 7'b1_10_00_01});
        offer(7'b0_00_10_11, 1'b1, 1'b1);
        chk("t2_mul_head", {gecerli, islem, hy, ky1, ky2}, {1'b1, 7'b0_00_10_11});
        chk("t2_bitir_early", bitir, 0);
        chk("t2_hazir_sealed", yaz_hazir, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t2_gecerli_after", gecerli, 0);
            chk("t2_bitir_after", bitir, 1);
            step();
        end
        do_reset();

        // 3: full boundary with the executor stalled
        durdur = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(7'(i * 11 + 3), 1'b0, 1'b1);
        end
        chk("t3_full", doluluk, 8);
        yaz_gecerli = 1'b1;
        {yaz_islem, yaz_hy, yaz_ky1, yaz_ky2} = 7'h7e;
        @(negedge saat);
        chk("t3_hazir_full", yaz_hazir, 0);
        step();
        chk("t3_still_full", doluluk, 8);
        durdur = 1'b0;
        @(negedge saat);
        chk("t3_hazir_full_pop", yaz_hazir, 0);
        step();
        durdur = 1'b1;
        chk("t3_after_pop", doluluk, 7);
        chk("t3_hazir_after_pop", yaz_hazir, 1);
        offer(7'h7e, 1'b0, 1'b1);
        chk("t3_refull", doluluk, 8);
        drain();
        do_reset();

        // 4: 20 back-to-back entries across pointer wrap
        durdur = 1'b0;
        for (int i = 0; i < 20; i++) begin
            offer(7'(i * 5 + 1), 1'b0, 1'b1);
            chk("t4_doluluk", doluluk, 1);
        end
        drain();
        do_reset();

        // 5: stall holds MUL R1<-R3,R2
        durdur = 1'b1;
        offer(7'b0_01_11_10, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {gecerli, islem, hy, ky1, ky2}, {1'b1, 7'b0_01_11_10});
            chk("t5_doluluk", doluluk, 1);
            step();
        end
        drain();
        do_reset();

        // 6: writes after the sealing entry are refused and never issued
        durdur = 1'b1;
        offer(7'h15, 1'b0, 1'b1);
        offer(7'h2a, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            offer(7'h4c, 1'b0, 1'b0);
            chk("t6_doluluk", doluluk, 2);
        end
        drain();
        step();
        step();
        chk("t6_bitir", bitir, 1);
        chk("t6_gecerli", gecerli, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
